// File: rtl/johnson_decoder_pkg.sv
// Shared definitions for the Johnson (twisted-ring) counter bus:
// decoder FSM state encoding and the phase successor function.
package johnson_decoder_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  // Successor phase of idx in a 2n-long Johnson sequence (2n-1 wraps to 0).
  function automatic int johnson_next(input int idx, input int n);
    return (idx >= 2 * n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_decoder_word_decode.sv
// Combinational Johnson word decode: code -> phase index plus legality flag.
module johnson_word_decode #(
  parameter int N  = 5,
  parameter int IW = 4
) (
  input  logic [N-1:0]  code_i,
  output logic [IW-1:0] idx_o,
  output logic          legal_o
);

  logic [IW-1:0] cnt;
  logic          hi_ok;
  logic          lo_ok;

  // Popcount, then check against the two legal shapes: 1..10..0 and 0..01..1.
  always_comb begin
    cnt   = '0;
    hi_ok = 1'b1;
    lo_ok = 1'b1;
    for (int i = 0; i < N; i++) cnt = cnt + IW'(code_i[i]);
    for (int i = 0; i < N; i++) begin
      hi_ok = hi_ok & (code_i[i] == (i >= N - int'(cnt)));
      lo_ok = lo_ok & (code_i[i] == (i < int'(cnt)));
    end
    legal_o = hi_ok | lo_ok;
    // Filling phase (MSB set, or all-zero) counts up; draining phase counts back from 2N.
    idx_o   = (code_i == '0 || code_i[N-1]) ? cnt : IW'(2 * N) - cnt;
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson bus receiver: registered decode, single-step sequencing check,
// lock tracking and a saturating error counter.
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter int N          = 5,
  parameter int IW         = 4,
  parameter bit ALLOW_HOLD = 1'b0,
  parameter int ECW        = 8
) (
  input  logic           clk_i,
  input  logic           clear_i,
  input  logic [N-1:0]   code_i,
  input  logic           code_valid_i,
  output logic [IW-1:0]  idx_o,
  output logic [2*N-1:0] onehot_o,
  output logic           idx_valid_o,
  output logic           illegal_o,
  output logic           skip_o,
  output logic           locked_o,
  output logic [ECW-1:0] err_count_o
);

  localparam int P = 2 * N;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d, prev_q, prev_d;
  logic [P-1:0]   onehot_q, onehot_d;
  logic           vld_q, vld_d, ill_q, ill_d, skp_q, skp_d;
  logic [ECW-1:0] err_q, err_d, err_inc;
  logic [IW-1:0]  dec_idx, succ;
  logic           dec_legal, hold_ok;

  johnson_word_decode #(.N(N), .IW(IW)) u_dec (
    .code_i  (code_i),
    .idx_o   (dec_idx),
    .legal_o (dec_legal)
  );

  assign succ    = IW'(johnson_next(int'(prev_q), N));
  assign hold_ok = ALLOW_HOLD && (dec_idx == prev_q);
  assign err_inc = (&err_q) ? err_q : err_q + ECW'(1);

  // Next-state: lock FSM, decoded outputs and error accounting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    vld_d   = vld_q;
    err_d   = err_q;
    ill_d   = 1'b0;
    skp_d   = 1'b0;
    if (code_valid_i) begin
      if (!dec_legal) begin
        // idx holds its last legal value; only the valid flag drops.
        state_d = ST_UNLOCKED;
        ill_d   = 1'b1;
        vld_d   = 1'b0;
        err_d   = err_inc;
      end else begin
        // Every legal word becomes the new base, including a resync after a skip.
        idx_d  = dec_idx;
        prev_d = dec_idx;
        vld_d  = 1'b1;
        if (state_q == ST_UNLOCKED) begin
          state_d = ST_LOCKED;
        end else if (dec_idx != succ && !hold_ok) begin
          state_d = ST_UNLOCKED;
          skp_d   = 1'b1;
          err_d   = err_inc;
        end
      end
    end
    onehot_d = vld_d ? (P'(1) << idx_d) : '0;
  end

  // State and output registers; clear aborts everything immediately.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q  <= ST_UNLOCKED;
      idx_q    <= '0;
      prev_q   <= '0;
      onehot_q <= '0;
      vld_q    <= 1'b0;
      ill_q    <= 1'b0;
      skp_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      prev_q   <= prev_d;
      onehot_q <= onehot_d;
      vld_q    <= vld_d;
      ill_q    <= ill_d;
      skp_q    <= skp_d;
      err_q    <= err_d;
    end
  end

  assign idx_o       = idx_q;
  assign onehot_o    = onehot_q;
  assign idx_valid_o = vld_q;
  assign illegal_o   = ill_q;
  assign skip_o      = skp_q;
  assign locked_o    = (state_q == ST_LOCKED);
  assign err_count_o = err_q;

endmodule
